// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared definitions for the WF8 fetch/decode/execute sequencer.
// Holds the state encoding (also visible on the debug state output) and the
// execute watchdog counter width.
// Optional build macro: SEQ_SINGLE_STEP_EN adds the PAUSE state (encoding 7).
package cpu_sequencer_pkg;

  localparam int unsigned SEQ_ST_W = 3;
  localparam int unsigned WDOG_W   = 4;

  typedef enum logic [SEQ_ST_W-1:0] {
    SEQ_ST_IDLE    = 3'd0,
    SEQ_ST_FETCH_A = 3'd1,
    SEQ_ST_FETCH_D = 3'd2,
    SEQ_ST_DECODE  = 3'd3,
    SEQ_ST_EXEC    = 3'd4,
    SEQ_ST_HALTED  = 3'd5,
    SEQ_ST_FAULT   = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
    , SEQ_ST_PAUSE = 3'd7
`endif
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: handshake/strobe bundle between the sequencer and the
// rest of the WF8 core (PC, RAM port, IR, decoder, bus_control).
//   master : the sequencer (drives strobes, state, insn_count)
//   slave  : the core environment (drives run, halt_req, insn_done,
//            insn_halt, pc_written and, with SEQ_SINGLE_STEP_EN, step)
// Parameter CNT_W: width of insn_count; must match the sequencer's CNT_W.
interface cpu_sequencer_if
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic                run;
  logic                halt_req;
  logic                insn_done;
  logic                insn_halt;
  logic                pc_written;
`ifdef SEQ_SINGLE_STEP_EN
  logic                step;
`endif
  logic                pc_out_en;
  logic                ram_en;
  logic                ram_out_en;
  logic                ir_load;
  logic                exec_en;
  logic                pc_inc;
  logic                halted;
  logic                fault;
  logic [SEQ_ST_W-1:0] state;
  logic [CNT_W-1:0]    insn_count;

  modport master (
    input  run, halt_req, insn_done, insn_halt, pc_written,
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    output pc_out_en, ram_en, ram_out_en, ir_load, exec_en, pc_inc,
    output halted, fault, state, insn_count
  );

  modport slave (
    output run, halt_req, insn_done, insn_halt, pc_written,
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    input  pc_out_en, ram_en, ram_out_en, ir_load, exec_en, pc_inc,
    input  halted, fault, state, insn_count
  );

endinterface

// File: rtl/cpu_sequencer_exec_watchdog.sv
// exec_watchdog: counts cycles spent executing one instruction.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (asserted while decoding)
//   en         : count one cycle (asserted while executing)
//   timeout    : count has reached MAX_EXEC_CYCLES-1
// MAX_EXEC_CYCLES legal range 1..15.
module exec_watchdog
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned MAX_EXEC_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == WDOG_W'(MAX_EXEC_CYCLES - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute state machine for the WF8 8-bit core.
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : cpu_sequencer_if.master -- run/halt_req/insn_done/insn_halt/
//           pc_written in; pc_out_en/ram_en/ram_out_en/ir_load/exec_en/
//           pc_inc/halted/fault/state/insn_count out
// Parameters: MAX_EXEC_CYCLES (1..15) execute cycles before FAULT,
//             CNT_W retired-instruction counter width.
// Optional build macro: SEQ_SINGLE_STEP_EN (step input, PAUSE after retire).
// Strobes are decoded from the state register; pc_inc is registered on the
// retire edge so it coincides with the following FETCH_A.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned MAX_EXEC_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input logic              clk,
  input logic              rst_n,
  cpu_sequencer_if.master  bus
);

  seq_state_e       state_q, state_d;
  logic             pc_inc_q, pc_inc_d;
  logic [CNT_W-1:0] insn_count_q, insn_count_d;
  logic             wdog_timeout;
  logic             retire;
  logic             stop_at_boundary;
  seq_state_e       after_retire;

  logic pc_out_en, ram_en, ram_out_en, ir_load, exec_en, halted, fault;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q, step_d;
  logic step_rise;
  assign step_d       = bus.step;
  assign step_rise    = bus.step & ~step_q;
  assign after_retire = SEQ_ST_PAUSE;
`else
  assign after_retire = SEQ_ST_FETCH_A;
`endif

  assign retire           = (state_q == SEQ_ST_EXEC) && bus.insn_done;
  assign stop_at_boundary = bus.halt_req || !bus.run;

  exec_watchdog #(
    .MAX_EXEC_CYCLES (MAX_EXEC_CYCLES)
  ) u_exec_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == SEQ_ST_DECODE),
    .en      (state_q == SEQ_ST_EXEC),
    .timeout (wdog_timeout)
  );

  // State register and the registered side effects of a retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SEQ_ST_IDLE;
      pc_inc_q     <= 1'b0;
      insn_count_q <= '0;
`ifdef SEQ_SINGLE_STEP_EN
      step_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_inc_q     <= pc_inc_d;
      insn_count_q <= insn_count_d;
`ifdef SEQ_SINGLE_STEP_EN
      step_q       <= step_d;
`endif
    end
  end

  always_comb begin
    pc_inc_d     = retire && !bus.pc_written;
    insn_count_d = insn_count_q + CNT_W'(retire);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_ST_IDLE:    if (bus.run) state_d = SEQ_ST_FETCH_A;
      SEQ_ST_FETCH_A: state_d = SEQ_ST_FETCH_D;
      SEQ_ST_FETCH_D: state_d = SEQ_ST_DECODE;
      SEQ_ST_DECODE:  state_d = bus.insn_halt ? SEQ_ST_HALTED : SEQ_ST_EXEC;
      SEQ_ST_EXEC: begin
        // insn_done takes priority over a coincident watchdog timeout.
        if (bus.insn_done) begin
          state_d = stop_at_boundary ? SEQ_ST_IDLE : after_retire;
        end else if (wdog_timeout) begin
          state_d = SEQ_ST_FAULT;
        end
      end
      SEQ_ST_HALTED:  if (!bus.run) state_d = SEQ_ST_IDLE;
      SEQ_ST_FAULT:   state_d = SEQ_ST_FAULT;
`ifdef SEQ_SINGLE_STEP_EN
      SEQ_ST_PAUSE: begin
        if (!bus.run) begin
          state_d = SEQ_ST_IDLE;
        end else if (step_rise) begin
          state_d = SEQ_ST_FETCH_A;
        end
      end
`endif
      default:        state_d = SEQ_ST_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    pc_out_en  = 1'b0;
    ram_en     = 1'b0;
    ram_out_en = 1'b0;
    ir_load    = 1'b0;
    exec_en    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      SEQ_ST_FETCH_A: begin
        pc_out_en = 1'b1;
        ram_en    = 1'b1;
      end
      SEQ_ST_FETCH_D: begin
        ram_out_en = 1'b1;
        ir_load    = 1'b1;
      end
      SEQ_ST_EXEC:    exec_en = 1'b1;
      SEQ_ST_HALTED:  halted  = 1'b1;
      SEQ_ST_FAULT:   fault   = 1'b1;
      default:        ;
    endcase
  end

  assign bus.pc_out_en  = pc_out_en;
  assign bus.ram_en     = ram_en;
  assign bus.ram_out_en = ram_out_en;
  assign bus.ir_load    = ir_load;
  assign bus.exec_en    = exec_en;
  assign bus.halted     = halted;
  assign bus.fault      = fault;
  assign bus.pc_inc     = pc_inc_q;
  assign bus.state      = state_q;
  assign bus.insn_count = insn_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer (default build).
// Each instruction is described by its execute latency and flags; the
// expected per-cycle trace (FETCH_A, FETCH_D, DECODE, EXEC..., retire or
// fault) is derived from that description. Inputs change on the falling
// edge; outputs are sampled on the falling edge before driving.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int unsigned MAXC = 4;
  localparam int unsigned CW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cpu_sequencer_if #(.CNT_W(CW)) bus ();

  cpu_sequencer #(
    .MAX_EXEC_CYCLES (MAXC),
    .CNT_W           (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;   // retired instructions since last reset (unbounded)
  bit at_fetch  = 0;   // DUT last observed in FETCH_A

`ifdef SEQ_SINGLE_STEP_EN
  initial bus.step = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {pc_out_en, ram_en, ram_out_en, ir_load, exec_en, halted, fault}
  function automatic logic [6:0] strobes_for(input int st);
    case (st)
      1:       return 7'b1100000;
      2:       return 7'b0011000;
      4:       return 7'b0000100;
      5:       return 7'b0000010;
      6:       return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic expect_cycle(input string tag, input int st, input bit pcinc);
    logic [31:0] cnt_mod;
    @(negedge clk);
    cnt_mod = 32'(exp_count) & ((32'd1 << CW) - 32'd1);
    check_eq({tag, ".state"}, 32'(bus.state), 32'(st));
    check_eq({tag, ".strobes"},
             32'({bus.pc_out_en, bus.ram_en, bus.ram_out_en, bus.ir_load,
                  bus.exec_en, bus.halted, bus.fault}),
             32'(strobes_for(st)));
    check_eq({tag, ".pc_inc"}, 32'(bus.pc_inc), 32'(pcinc));
    check_eq({tag, ".count"}, 32'(bus.insn_count), cnt_mod);
    at_fetch = (st == 1);
  endtask

  task automatic do_reset(input string tag);
    rst_n        = 1'b0;
    bus.halt_req = 1'b0;
    bus.insn_done = 1'b0;
    bus.pc_written = 1'b0;
    bus.insn_halt = 1'b0;
    exp_count    = 0;
    expect_cycle(tag, 0, 0);
    rst_n        = 1'b1;
  endtask

  task automatic ensure_fetch();
    if (!at_fetch) begin
      bus.run      = 1'b1;
      bus.halt_req = 1'b0;
      expect_cycle("start", 1, 0);
    end
  endtask

  // lat: cycle of insn_done within EXEC (1-based); lat > MAXC never completes.
  // rst_at: EXEC cycle index at which reset is applied (-1 = none).
  task automatic run_insn(input int lat, input bit jmp, input bit hinsn,
                          input bit stop_run, input bit stop_hreq, input int rst_at);
    ensure_fetch();
    bus.insn_done  = 1'b0;
    bus.pc_written = 1'b0;
    bus.insn_halt  = 1'b0;
    expect_cycle("fetch_d", 2, 0);
    bus.halt_req = stop_hreq;
    expect_cycle("decode", 3, 0);
    bus.insn_halt = hinsn;
    if (hinsn) begin
      expect_cycle("halted", 5, 0);
      bus.insn_halt = 1'b0;
      bus.halt_req  = 1'b0;
      repeat (2) expect_cycle("halted_hold", 5, 0);
      bus.run = 1'b0;
      expect_cycle("halt_exit", 0, 0);
      return;
    end
    for (int i = 0; i <= MAXC; i++) begin
      expect_cycle("exec", 4, 0);
      bus.insn_halt = 1'b0;
      if (i == rst_at) begin
        do_reset("rst_mid_exec");
        return;
      end
      if (i == lat - 1) begin
        bus.insn_done  = 1'b1;
        bus.pc_written = jmp;
        if (stop_run) bus.run = 1'b0;
        exp_count++;
        expect_cycle("retire", (stop_run || stop_hreq) ? 0 : 1, !jmp);
        bus.insn_done  = 1'b0;
        bus.pc_written = 1'b0;
        bus.halt_req   = 1'b0;
        if (stop_run) expect_cycle("idle_hold", 0, 0);
        return;
      end
      if (i == MAXC - 1) begin
        expect_cycle("fault", 6, 0);
        bus.run = 1'b1;
        repeat (3) expect_cycle("fault_sticky", 6, 0);
        do_reset("fault_reset");
        return;
      end
    end
  endtask

  initial begin
    bus.run        = 1'b1;
    bus.halt_req   = 1'b0;
    bus.insn_done  = 1'b0;
    bus.insn_halt  = 1'b0;
    bus.pc_written = 1'b0;
    rst_n          = 1'b0;
    expect_cycle("reset", 0, 0);
    expect_cycle("reset2", 0, 0);
    rst_n = 1'b1;
    expect_cycle("first_fetch", 1, 0);

    run_insn(1, 0, 0, 0, 0, -1);          // ADD: retires 4 cycles after FETCH_A
    run_insn(2, 0, 0, 0, 0, -1);          // LB: two EXEC cycles
    run_insn(1, 1, 0, 0, 0, -1);          // jump: no pc_inc
    run_insn(MAXC, 0, 0, 0, 0, -1);       // done on the timeout cycle wins
    run_insn(1, 0, 0, 0, 1, -1);          // halt_req during FETCH_D
    run_insn(2, 0, 0, 1, 0, -1);          // run dropped at retire
    run_insn(1, 0, 1, 0, 0, -1);          // HALT instruction
    run_insn(3, 0, 0, 0, 0, 1);           // reset mid-EXEC
    run_insn(MAXC + 1, 0, 0, 0, 0, -1);   // hung instruction -> FAULT
    for (int k = 0; k < 16; k++) run_insn(1, k % 3 == 0, 0, 0, 0, -1);
    check_eq("count_wrap", 32'(bus.insn_count), 32'd0);

    for (int n = 0; n < 80; n++) begin
      int lat;
      int rst_at;
      lat    = ($urandom_range(0, 11) == 0) ? MAXC + 1 : $urandom_range(1, MAXC);
      rst_at = ($urandom_range(0, 19) == 0 && lat <= MAXC) ? $urandom_range(0, lat - 1) : -1;
      run_insn(lat, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, rst_at);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL sim_timeout: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Top-level fetch/decode/execute state machine for the WF8 8-bit core.
- Fetches each instruction from RAM using the PC.
- Hands the instruction to the decoder and bus control, then waits for insn_done.
- Advances the PC, counts retired instructions and detects hung instructions with an execute watchdog.
- Sits between the PC register, the RAM port, the instruction register and bus_control.

Parameters:
MAX_EXEC_CYCLES, 4, cycles allowed in EXEC before FAULT; legal range 1..15.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
run  in  1  level; 1 = start/continue execution
halt_req  in  1  level; stop at the next instruction boundary
insn_done  in  1  from bus_control; last cycle of the executing instruction
insn_halt  in  1  from decoder; decoded instruction is HALT (valid in DECODE)
pc_written  in  1  from bus_control; PC was loaded by the current instruction (jump), valid with insn_done
pc_out_en  out  1  PC drives the RAM address
ram_en  out  1  RAM latches the address
ram_out_en  out  1  RAM drives the data bus
ir_load  out  1  instruction register captures the data bus
exec_en  out  1  enables decoder/bus_control for the current instruction
pc_inc  out  1  one-cycle PC increment pulse
halted  out  1  in HALTED state
fault  out  1  in FAULT state
state  out  3  current state encoding (debug)
insn_count  out  CNT_W  retired-instruction count

Behaviour:
- All outputs are decoded from the state register only (Moore). pc_inc is the only exception: it is registered on the insn_done transition.
- Reset (rst_n=0 at posedge): state=IDLE, every output 0, insn_count=0, watchdog=0. This overrides any state, including mid-EXEC.
- IDLE: all strobes 0. run=1 -> FETCH_A.
- FETCH_A (1 cycle): pc_out_en=1, ram_en=1 -> FETCH_D.
- FETCH_D (1 cycle): ram_out_en=1, ir_load=1 -> DECODE.
  - RAM read latency is exactly 1 cycle after ram_en.
- DECODE (1 cycle): no strobes.
  - insn_halt=1 -> HALTED; PC is not incremented.
  - Otherwise -> EXEC with the watchdog cleared.
- EXEC: exec_en=1; the watchdog increments each cycle.
  - insn_done=1: insn_count+1 (wraps at 2^CNT_W). pc_inc pulses 1 in the following cycle unless pc_written=1.
    - Next state is IDLE if halt_req=1 or run=0; otherwise FETCH_A.
  - insn_done=0 with watchdog==MAX_EXEC_CYCLES-1 -> FAULT.
  - If insn_done and the timeout coincide, insn_done wins.
- HALTED: halted=1. run=0 -> IDLE.
- FAULT: fault=1. Sticky until reset; run is ignored.
- Timing:
  - A 1-cycle instruction retires 4 cycles after FETCH_A entry.
  - A 2-cycle instruction (LB) retires after 5 cycles.
- halt_req and run=0 are honoured only at instruction boundaries; a fetch or execute in progress is never aborted.
- pc_inc and the next FETCH_A are in the same cycle. The PC register must apply the increment before the address is sampled (the increment is combinational into the PC mux).
- State encoding:
  - IDLE=0, FETCH_A=1, FETCH_D=2, DECODE=3, EXEC=4, HALTED=5, FAULT=6.
  - 7 is illegal -> IDLE on the next cycle.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined:
  - Adds input step (1 bit) and state PAUSE=7.
  - After each retire, go to PAUSE instead of FETCH_A when run=1.
  - PAUSE -> FETCH_A on a step rising edge (step registered once internally).
  - PAUSE -> IDLE if run=0.
- Undefined: no step port; encoding 7 remains illegal.

Decomposition:
- State encodings (`SEQ_ST_*`) and the state width go in the shared param.vh alongside the ISA constants.
- One sub-module: exec_watchdog.
  - Ports: clk, rst_n, clr, en, timeout.
  - 4-bit counter, compared against MAX_EXEC_CYCLES-1.

Test Plan:
- Reset, then run=1 with a 1-cycle ADD:
  - FETCH_A at cycle 1 (pc_out_en=1, ram_en=1), ir_load at cycle 2, exec_en at cycle 4.
  - insn_done at cycle 4 -> pc_inc=1 and FETCH_A at cycle 5; insn_count=1.
- LB with insn_done in the 2nd EXEC cycle -> exec_en high for exactly 2 cycles; insn_count increments once.
- Jump with insn_done=1 and pc_written=1 -> pc_inc stays 0; next FETCH_A still follows.
- insn_done never asserted with MAX_EXEC_CYCLES=4 -> fault=1 after 4 EXEC cycles; state=6 persists with run=1 until rst_n=0, then all outputs 0.
- halt_req=1 during FETCH_D -> the current instruction completes, state=IDLE after retire. insn_halt in DECODE -> halted=1, no pc_inc; run=0 -> IDLE.
- CNT_W=4 with 16 retires -> insn_count wraps to 0. rst_n=0 in EXEC mid-instruction -> IDLE next cycle, insn_count=0.
